// File: rtl/hilo_div_unit_pkg.sv
// Shared definitions for the HI/LO iterative divider: FSM encoding and iteration constants.
package hilo_div_unit_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } div_state_t;

   localparam int DIV_ITERS = 32;
   localparam int CNT_W     = 6;

endpackage

// File: rtl/hilo_div_unit_if.sv
// Execute-stage to divider handshake and HI/LO write-port bundle.
interface hilo_div_unit_if #(parameter int WIDTH = 32) ();

   logic             start;
   logic             signed_op;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             cancel;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;
   logic             hi_reg_write;
   logic             lo_reg_write;

   modport master (
      output start, signed_op, dividend, divisor, cancel,
      input  busy, done, hi_out, lo_out, hi_reg_write, lo_reg_write
   );

   modport slave (
      input  start, signed_op, dividend, divisor, cancel,
      output busy, done, hi_out, lo_out, hi_reg_write, lo_reg_write
   );

endinterface

// File: rtl/hilo_div_unit_div_iter_step.sv
// One radix-2 restoring-division iteration: shift {rem, quo} left, trial-subtract, restore.
module div_iter_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_dvs,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);

   logic [WIDTH:0] w_part;
   logic [WIDTH:0] w_diff;

   assign w_part = {i_rem, i_quo[WIDTH-1]};
   assign w_diff = w_part - {1'b0, i_dvs};

   // Partial remainder stays below the divisor, so a non-negative difference fits in WIDTH bits.
   always_comb begin
      o_rem = w_part[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b0};
      if (!w_diff[WIDTH]) begin
         o_rem = w_diff[WIDTH-1:0];
         o_quo = {i_quo[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/hilo_div_unit.sv
// MIPS DIV/DIVU engine: operand latch, 32-cycle restoring loop, sign fix, HI/LO write pulse.
// state  | meaning
// S_IDLE | waiting for start
// S_CALC | one shift/subtract iteration per cycle
// S_FIX  | sign correction, results registered
// S_DONE | one-cycle write pulse to HI/LO
module hilo_div_unit
   import hilo_div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_ITERS
) (
   input logic           clk,
   input logic           rst,
   hilo_div_unit_if.slave bus
);

   div_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvs;
   logic             r_quo_neg;
   logic             r_rem_neg;
   logic             r_dvs_zero;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_quo_nxt;
   logic             w_dvd_neg;
   logic             w_dvs_neg;
   logic             w_pulse;

   div_iter_step #(.WIDTH(WIDTH)) u_step (
      .i_rem (r_rem),
      .i_quo (r_quo),
      .i_dvs (r_dvs),
      .o_rem (w_rem_nxt),
      .o_quo (w_quo_nxt)
   );

   assign w_dvd_neg = bus.signed_op & bus.dividend[WIDTH-1];
   assign w_dvs_neg = bus.signed_op & bus.divisor[WIDTH-1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_dvs      <= '0;
         r_quo_neg  <= 1'b0;
         r_rem_neg  <= 1'b0;
         r_dvs_zero <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
      end else if (bus.cancel) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_quo      <= w_dvd_neg ? -bus.dividend : bus.dividend;
                  r_dvs      <= w_dvs_neg ? -bus.divisor : bus.divisor;
                  r_quo_neg  <= w_dvd_neg ^ w_dvs_neg;
                  r_rem_neg  <= w_dvd_neg;
                  r_dvs_zero <= (bus.divisor == '0);
                  r_rem      <= '0;
                  r_cnt      <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= S_CALC;
               end
            end
            S_CALC: begin
               r_rem <= w_rem_nxt;
               r_quo <= w_quo_nxt;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(WIDTH - 1))
                  r_state <= S_FIX;
            end
            S_FIX: begin
               // With a zero divisor the remainder is |dividend|; re-applying its sign returns the raw dividend.
               r_lo    <= r_dvs_zero ? '1 : (r_quo_neg ? -r_quo : r_quo);
               r_hi    <= r_rem_neg ? -r_rem : r_rem;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // A flush arriving in the DONE cycle must kill the write in that same cycle.
   assign w_pulse          = r_done & ~bus.cancel;
   assign bus.busy         = r_busy;
   assign bus.done         = w_pulse;
   assign bus.hi_reg_write = w_pulse;
   assign bus.lo_reg_write = w_pulse;
   assign bus.hi_out       = r_hi;
   assign bus.lo_out       = r_lo;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit: latency, signed/unsigned results, cancel, reset, ignored start.
module tb_hilo_div_unit;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   hilo_div_unit_if #(.WIDTH(32)) bus ();

   hilo_div_unit #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issues one op, optionally pulses a stray start mid-flight, and checks latency, results and pulse width.
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi, input int glitch_at);
      int cyc;
      @(negedge clk);
      bus.start     = 1'b1;
      bus.signed_op = sgn;
      bus.dividend  = a;
      bus.divisor   = b;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      cyc = 0;
      while (!bus.done && cyc < 100) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (cyc == glitch_at) begin
            bus.start     = 1'b1;
            bus.signed_op = ~sgn;
            bus.dividend  = 32'd50;
            bus.divisor   = 32'd5;
         end else begin
            bus.start     = 1'b0;
            bus.signed_op = sgn;
            bus.dividend  = a;
            bus.divisor   = b;
         end
      end
      bus.start = 1'b0;
      chk({tag, "_lat"}, 32'(cyc), 32'd33);
      chk({tag, "_lo"}, bus.lo_out, exp_lo);
      chk({tag, "_hi"}, bus.hi_out, exp_hi);
      chk({tag, "_we"}, {30'd0, bus.hi_reg_write, bus.lo_reg_write}, 32'd3);
      @(negedge clk);
      chk({tag, "_we_off"}, {29'd0, bus.done, bus.hi_reg_write, bus.lo_reg_write}, 32'd0);
      chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int saw_done;
      n_checks      = 0;
      n_errors      = 0;
      rst           = 1'b0;
      bus.start     = 1'b0;
      bus.signed_op = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus.cancel    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_we", {30'd0, bus.done, bus.hi_reg_write}, 32'd0);
      chk("rst_hi", bus.hi_out, 32'd0);
      chk("rst_lo", bus.lo_out, 32'd0);
      rst = 1'b1;

      run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 0);
      run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0);
      run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 0);
      run_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 0);
      run_div("divu_by0", 1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 0);
      run_div("div_m8_by0", 1'b1, 32'hFFFFFFF8, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF8, 0);
      run_div("divu_big", 1'b0, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'h00000001, 0);
      run_div("ign_start", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 5);

      // Cancel at CALC cycle 10: no pulse, outputs hold the previous result.
      @(negedge clk);
      bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      saw_done = 0;
      repeat (9) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done || bus.hi_reg_write || bus.lo_reg_write) saw_done = 1;
      end
      bus.cancel = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.cancel = 1'b0;
      chk("cancel_busy", 32'(bus.busy), 32'd0);
      repeat (40) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done || bus.hi_reg_write || bus.lo_reg_write) saw_done = 1;
      end
      chk("cancel_nowrite", 32'(saw_done), 32'd0);
      chk("cancel_hold_lo", bus.lo_out, 32'h0000000E);
      run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0);

      // cancel together with start in IDLE: nothing accepted
      @(negedge clk);
      bus.start = 1'b1; bus.cancel = 1'b1; bus.dividend = 32'd40; bus.divisor = 32'd4;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0; bus.cancel = 1'b0;
      chk("cancel_start_busy", 32'(bus.busy), 32'd0);

      // cancel in the DONE cycle gates the pulse combinationally
      @(negedge clk);
      bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd40; bus.divisor = 32'd4;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 100 && !bus.done; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("done_seen", 32'(bus.done), 32'd1);
      bus.cancel = 1'b1;
      #1;
      chk("cancel_done_gate", {29'd0, bus.done, bus.hi_reg_write, bus.lo_reg_write}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      bus.cancel = 1'b0;
      chk("cancel_done_busy", 32'(bus.busy), 32'd0);

      // reset at cycle 20 of an operation
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 32'd77; bus.divisor = 32'd7;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (19) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_ctl", {29'd0, bus.busy, bus.done, bus.hi_reg_write}, 32'd0);
      chk("mid_rst_hi", bus.hi_out, 32'd0);
      chk("mid_rst_lo", bus.lo_out, 32'd0);
      rst = 1'b1;
      saw_done = 0;
      repeat (40) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done) saw_done = 1;
      end
      chk("mid_rst_nowrite", 32'(saw_done), 32'd0);
      run_div("post_rst", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/hilo_div_unit.md
# hilo_div_unit

Iterative 32-bit divider that drives the HI/LO register write ports for MIPS DIV and DIVU. It accepts one operation from the execute stage, runs a fixed-latency radix-2 restoring division, and then raises the write enables for one cycle. The remainder goes to HI and the quotient to LO. The pipeline stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, default 32: operand, quotient and remainder width.

Ports:
- `clk`  in  1: sole clock; all state changes on its rising edge.
- `rst`  in  1: reset, synchronous, active-low. Sampled on the `clk` rising edge; `rst`=0 resets.
- `start`  in  1: request a divide; accepted only in IDLE.
- `signed_op`  in  1: 1 = DIV (two's complement), 0 = DIVU; sampled with `start`.
- `dividend`  in  WIDTH: rs operand; sampled with `start`.
- `divisor`  in  WIDTH: rt operand; sampled with `start`.
- `cancel`  in  1: flush from exception or branch mispredict; abandons the operation without writing.
- `busy`  out  1: high from the cycle after acceptance through the DONE cycle.
- `done`  out  1: one-cycle pulse; results valid.
- `hi_out`  out  WIDTH: remainder; feeds the HI data input.
- `lo_out`  out  WIDTH: quotient; feeds the LO data input.
- `hi_reg_write`  out  1: HI write enable; equals `done`.
- `lo_reg_write`  out  1: LO write enable; equals `done`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, `start`=1, `cancel`=0:
  - latch absolute values of operands (signed mode) or raw values (unsigned);
  - latch quotient-sign = sign(dividend) XOR sign(divisor), and remainder-sign = sign(dividend);
  - clear remainder accumulator and counter; go to CALC.
- CALC, one iteration per cycle:
  - shift {rem, quo} left by 1 and trial-subtract the divisor from the WIDTH+1-bit partial remainder;
  - if non-negative, keep the difference and set quo LSB = 1; otherwise restore and set LSB = 0;
  - after WIDTH iterations, go to FIX.
- FIX:
  - negate the quotient if quotient-sign=1; negate the remainder if remainder-sign=1 (signed mode only);
  - register the results into `hi_out`/`lo_out`; go to DONE.
- DONE: `done`=`hi_reg_write`=`lo_reg_write`=1 for exactly one cycle, then IDLE.
- Divisor = 0, both modes: sign fix is skipped; LO=all-ones, HI=dividend as presented. Full latency still applies.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This is the natural algorithm result; no trap is raised.
- Remainder sign always follows the dividend, per MIPS truncating division.
- `start` while `busy` is ignored; operands are not re-sampled.

## Timing
- Reset (`rst`=0):
  - state returns to IDLE;
  - `busy`, `done`, `hi_reg_write`, `lo_reg_write` = 0;
  - `hi_out`, `lo_out` = 0;
  - counter = 0.
- Reset mid-operation aborts with no write.
- Start accepted at edge E0:
  - `busy`=1 from E0 onward;
  - CALC occupies edges E1..E32; FIX completes at E33;
  - `done` is high in the cycle between E33 and E34;
  - HI/LO capture the result at E34;
  - `busy` falls after E34.
- Total latency, start edge to HI/LO update: 34 cycles. A back-to-back `start` is accepted earliest at E34.
- `cancel`=1 in any non-IDLE state: IDLE at the next edge, no write enables, outputs hold their previous values.
  - `cancel` during DONE suppresses `done` and both write enables in that same cycle; they are gated combinationally.
- `cancel` and `start` together in IDLE: `cancel` wins; nothing is accepted.
- `rst` has priority over `cancel`, and `cancel` over `start`.

## Structure
- Shared CPU package holds:
  - the state encoding (2-bit enum: IDLE, CALC, FIX, DONE);
  - `DIV_ITERS` = 32;
  - the counter width constant, 6 bits.
- One sub-module is natural: `div_iter_step`. It is combinational and performs one shift/trial-subtract/restore iteration on {rem, quo, divisor}, so it can be unit-tested and later unrolled to radix-4.
- Top-level contents: FSM, operand latches, sign fix, and output registers.

## Test plan
- DIVU 100 / 7: `done` exactly 33 cycles after the start edge → LO=0x0000000E, HI=0x00000002; write enables high for exactly 1 cycle.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 7 / −2 → LO=0xFFFFFFFD, HI=0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 0x12345678 / 0 → LO=0xFFFFFFFF, HI=0x12345678 after full latency.
- Start, then `cancel` at CALC cycle 10:
  - no write pulse; `busy` low after the next edge;
  - an immediately following DIVU 9/3 yields LO=3, HI=0.
- Separately, `rst`=0 at cycle 20: all outputs 0 at the next edge.
- `start` pulsed during `busy` with different operands: ignored; the original result is delivered.
